// File: rtl/scr1_sha256_pkg.sv
// SHA-256 shared definitions: FSM state encoding, round constants, IV and
// the FIPS 180-4 bit-mixing functions used by the core and its round logic.
// Purely declarative; no clocked logic, so no latency or backpressure.
package scr1_sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Sigma0: rotr 2 ^ rotr 13 ^ rotr 22
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Sigma1: rotr 6 ^ rotr 11 ^ rotr 25
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // sigma0: rotr 7 ^ rotr 18 ^ shr 3
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1: rotr 17 ^ rotr 19 ^ shr 10
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/scr1_sha256_round.sv
// One SHA-256 compression round: next working variables from a..h, Kt, Wt.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result every cycle it needs it.
// Ports: a..h current working variables, kt round constant, wt schedule word,
//        na..nh next working variables.
module scr1_sha256_round
  import scr1_sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] kt,
  input  logic [31:0] wt,
  output logic [31:0] na,
  output logic [31:0] nb,
  output logic [31:0] nc,
  output logic [31:0] nd,
  output logic [31:0] ne,
  output logic [31:0] nf,
  output logic [31:0] ng,
  output logic [31:0] nh
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = h + big_sigma1(e) + ch(e, f, g) + kt + wt;
    t2 = big_sigma0(a) + maj(a, b, c);
  end

  assign na = t1 + t2;
  assign nb = a;
  assign nc = b;
  assign nd = c;
  assign ne = d + t1;
  assign nf = e;
  assign ng = f;
  assign nh = g;

endmodule

// File: rtl/scr1_sha256_core.sv
// SHA-256 compression engine: one 512-bit block per start, one round per cycle.
// Latency: start to done is 65 cycles (64 rounds + 1 chaining-update cycle).
// Backpressure: start and blk_wr are dropped while busy; init aborts at any time.
// Ports: clk, rst_n (async active-low); init loads the IV; start launches a block;
//        blk_wr/blk_idx/blk_wdata fill the 16-word message buffer; hash_idx selects
//        the chaining word returned combinationally on hash_rdata; busy, done status.
// Build option: SCR1_SHA256_BSWAP_EN byte-reverses words on write and on read-back,
//        letting a little-endian CPU store message bytes in natural order.
module scr1_sha256_core
  import scr1_sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        start,
  input  logic        blk_wr,
  input  logic [3:0]  blk_idx,
  input  logic [31:0] blk_wdata,
  input  logic [2:0]  hash_idx,
  output logic [31:0] hash_rdata,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic [5:0]  t;
  logic [31:0] w  [16];   // message buffer, overwritten in place by the schedule
  logic [31:0] hv [8];    // chaining value H0..H7
  logic [31:0] wv [8];    // working variables a..h
  logic [31:0] nv [8];    // round result

  logic [31:0] wdata_in;
  logic [31:0] wt;
  logic [31:0] w_sched;
  logic [3:0]  t_lo;
  logic [3:0]  i2;
  logic [3:0]  i7;
  logic [3:0]  i15;

`ifdef SCR1_SHA256_BSWAP_EN
  assign wdata_in   = bswap32(blk_wdata);
  assign hash_rdata = bswap32(hv[hash_idx]);
`else
  assign wdata_in   = blk_wdata;
  assign hash_rdata = hv[hash_idx];
`endif

  // Circular schedule: slot t mod 16 still holds W[t-16] when round t runs,
  // so the new word reuses that slot once it has been read.
  always_comb begin
    t_lo    = t[3:0];
    i2      = t_lo - 4'd2;
    i7      = t_lo - 4'd7;
    i15     = t_lo - 4'd15;
    w_sched = small_sigma1(w[i2]) + w[i7] + small_sigma0(w[i15]) + w[t_lo];
    wt      = (t[5:4] == 2'b00) ? w[t_lo] : w_sched;
  end

  scr1_sha256_round u_round (
    .a  (wv[0]),
    .b  (wv[1]),
    .c  (wv[2]),
    .d  (wv[3]),
    .e  (wv[4]),
    .f  (wv[5]),
    .g  (wv[6]),
    .h  (wv[7]),
    .kt (K[t]),
    .wt (wt),
    .na (nv[0]),
    .nb (nv[1]),
    .nc (nv[2]),
    .nd (nv[3]),
    .ne (nv[4]),
    .nf (nv[5]),
    .ng (nv[6]),
    .nh (nv[7])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      t     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= IV[i];
        wv[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (init) begin
        // Also blocks a same-cycle start or write; a running block is abandoned.
        state <= ST_IDLE;
        busy  <= 1'b0;
        for (int i = 0; i < 8; i++) hv[i] <= IV[i];
      end else begin
        case (state)
          ST_IDLE: begin
            if (blk_wr) w[blk_idx] <= wdata_in;
            if (start) begin
              for (int i = 0; i < 8; i++) wv[i] <= hv[i];
              t     <= '0;
              busy  <= 1'b1;
              state <= ST_ROUND;
            end
          end
          ST_ROUND: begin
            for (int i = 0; i < 8; i++) wv[i] <= nv[i];
            if (t[5:4] != 2'b00) w[t_lo] <= wt;
            t <= t + 6'd1;
            if (t == LAST_ROUND) state <= ST_FINAL;
          end
          ST_FINAL: begin
            for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scr1_sha256_core.sv
// Bench for scr1_sha256_core: directed message blocks against a whole-block
// SHA-256 reference model plus literal FIPS digests.
module tb_scr1_sha256_core;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        start;
  logic        blk_wr;
  logic [3:0]  blk_idx;
  logic [31:0] blk_wdata;
  logic [2:0]  hash_idx;
  logic [31:0] hash_rdata;
  logic        busy;
  logic        done;

  scr1_sha256_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .start      (start),
    .blk_wr     (blk_wr),
    .blk_idx    (blk_idx),
    .blk_wdata  (blk_wdata),
    .hash_idx   (hash_idx),
    .hash_rdata (hash_rdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_H = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_H = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2    = {480'h0, 32'h000001c0};

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Bus-side view of a big-endian word (write data and read-back share it).
  function automatic logic [31:0] bus_map(input logic [31:0] x);
`ifdef SCR1_SHA256_BSWAP_EN
    return bsw(x);
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block reference: returns {new H, W[48..63]} (the latter is what an
  // in-place schedule leaves in the 16-word buffer).
  function automatic logic [767:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, t1, t2;
    logic [767:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[767-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = w[48+i];
    return r;
  endfunction

  // ---------------- transaction-level model ----------------
  logic [255:0] m_h;
  logic [255:0] m_res;
  logic [511:0] m_wnext;
  logic [31:0]  m_w [16];
  int           m_cnt;    // cycles until the running block completes
  logic         m_done;

  function automatic logic [511:0] blk_now();
    logic [511:0] b;
    for (int i = 0; i < 16; i++)
      b[511-32*i -: 32] = (blk_wr && int'(blk_idx) == i) ? bus_map(blk_wdata) : m_w[i];
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h    <= IV_H;
      m_cnt  <= 0;
      m_done <= 1'b0;
      for (int i = 0; i < 16; i++) m_w[i] <= '0;
    end else begin
      m_done <= 1'b0;
      if (init) begin
        m_h   <= IV_H;
        m_cnt <= 0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_h    <= m_res;
          m_done <= 1'b1;
          for (int i = 0; i < 16; i++) m_w[i] <= m_wnext[511-32*i -: 32];
        end
      end else begin
        if (blk_wr) m_w[blk_idx] <= bus_map(blk_wdata);
        if (start) begin
          m_cnt <= 65;
          {m_res, m_wnext} <= compress(m_h, blk_now());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("hash_rdata", hash_rdata, bus_map(m_h[255-32*int'(hash_idx) -: 32]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    init     = 1'b0;
    start    = 1'b0;
    blk_wr   = 1'b0;
    hash_idx = hash_idx + 3'd1;
  endtask

  task automatic write_block(input logic [511:0] blk, input bit start_on_last);
    for (int i = 0; i < 16; i++) begin
      blk_wr    = 1'b1;
      blk_idx   = 4'(i);
      blk_wdata = bus_map(blk[511-32*i -: 32]);
      if (i == 15 && start_on_last) start = 1'b1;
      step();
    end
  endtask

  task automatic wait_done(input int exp_cycles, input string name);
    int n = 0;
    for (int i = 1; i <= 200 && n == 0; i++) begin
      step();
      if (done) n = i;
    end
    chk(name, n, exp_cycles);
  endtask

  // Literal digest word: checks both the DUT and the model.
  task automatic check_lit(input int idx, input logic [31:0] val, input string name);
    hash_idx = 3'(idx);
    @(negedge clk);
    #1;
    chk(name, hash_rdata, bus_map(val));
    chk({name, "_model"}, m_h[255-32*idx -: 32], val);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; init = 1'b0; start = 1'b0; blk_wr = 1'b0;
    blk_idx = '0; blk_wdata = '0; hash_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 8; i++) check_lit(i, IV_H[255-32*i -: 32], "reset_iv");
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);

    // Empty message
    init = 1'b1; step();
    write_block(BLK_EMPTY, 1'b0);
    start = 1'b1; step();
    wait_done(65, "empty_latency");
    check_lit(0, 32'he3b0c442, "empty_h0");
    check_lit(7, 32'h7852b855, "empty_h7");

    // "abc", last word written in the start cycle
    init = 1'b1; step();
    write_block(BLK_ABC, 1'b1);
    wait_done(65, "abc_latency");
    for (int i = 0; i < 8; i++) check_lit(i, ABC_H[255-32*i -: 32], "abc_h");

    // Two-block message, chaining without init
    init = 1'b1; step();
    write_block(BLK_M1, 1'b0);
    start = 1'b1; step();
    wait_done(65, "m1_latency");
    write_block(BLK_M2, 1'b0);
    start = 1'b1; step();
    wait_done(65, "m2_latency");
    check_lit(0, 32'h248d6a61, "two_block_h0");
    check_lit(7, 32'h19db06c1, "two_block_h7");

    // Abort mid-compression
    init = 1'b1; step();
    write_block(BLK_ABC, 1'b0);
    start = 1'b1; step();
    repeat (20) step();
    init = 1'b1; step();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    check_lit(0, IV_H[255:224], "abort_iv");

    // init and start together: init wins
    write_block(BLK_ABC, 1'b0);
    init = 1'b1; start = 1'b1; step();
    chk("init_start_busy", {31'b0, busy}, 32'd0);
    repeat (3) step();

    // start and blk_wr while busy are ignored
    start = 1'b1; step();
    repeat (10) step();
    start = 1'b1; blk_wr = 1'b1; blk_idx = 4'd0; blk_wdata = 32'hffffffff; step();
    repeat (5) step();
    blk_wr = 1'b1; blk_idx = 4'd15; blk_wdata = 32'h12345678; step();
    wait_done(48, "ignore_latency");
    // Back-to-back start in the done cycle, on the consumed buffer
    start = 1'b1; step();
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      hash_idx = 3'(i);
      #1 chk("ignore_abc_h_during_busy", hash_rdata, bus_map(ABC_H[255-32*i -: 32]));
    end
    wait_done(65, "b2b_latency");
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
